// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pulls one word per frame from a FIFO and
// serialises it as start bit, WIDTH data bits (LSB first) and one stop bit.
`timescale 1ns/1ps

module fifo_uart_tx #(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_empty,
    output logic             o_rden,
    input  logic [WIDTH-1:0] i_rddata,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BitW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [BitW-1:0] BitLast = BitW'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StStart,
        StData,
        StStop
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [BitW-1:0]   bit_q, bit_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              done_q, done_d;
    logic              bit_end;

    // State and datapath registers; reset forces the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic; tx_d is the line level for the state/bit being entered.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        bit_end = (cnt_q == CntLast);
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!i_empty) begin
                    state_d = StFetch;
                end
            end
            StFetch: begin
                shreg_d = i_rddata;
                cnt_d   = '0;
                bit_d   = '0;
                tx_d    = 1'b0;
                state_d = StStart;
            end
            StStart: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    tx_d    = shreg_q[0];
                    state_d = StData;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (bit_end) begin
                    cnt_d = '0;
                    if (bit_q == BitLast) begin
                        tx_d    = 1'b1;
                        state_d = StStop;
                    end else begin
                        shreg_d = shreg_q >> 1;
                        tx_d    = shreg_d[0];
                        bit_d   = bit_q + BitW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StStop: begin
                if (bit_end) begin
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                tx_d    = 1'b1;
            end
        endcase
    end

    // Outputs; read enable is gated by reset so it stays low while rst_n is low.
    always_comb begin
        o_rden = rst_n && (state_q == StIdle) && !i_empty;
        o_busy = (state_q != StIdle);
        o_tx   = tx_q;
        o_done = done_q;
    end

endmodule

// File: doc/fifo_uart_tx.md
FIFO_UART_TX -- requirements
Module: fifo_uart_tx

Interface
REQ-001 Parameter WIDTH, default 8: data bits per frame; equals the FIFO data width.
REQ-002 Parameter CLKS_PER_BIT, default 868: clk cycles per serial bit (100 MHz / 115200); legal values >= 2.
REQ-003 clk  input  1: single system clock; all state changes on its rising edge.
REQ-004 rst_n  input  1: asynchronous, active-low reset.
REQ-005 i_empty  input  1: FIFO empty flag.
REQ-006 o_rden  output  1: FIFO read enable, one-cycle pulse per fetched word.
REQ-007 i_rddata  input  WIDTH: FIFO read data; valid the cycle after o_rden is sampled high.
REQ-008 o_tx  output  1: serial line, 8N1-style (start, WIDTH data bits LSB first, 1 stop); idle high.
REQ-009 o_busy  output  1: high while a word is being fetched or transmitted.
REQ-010 o_done  output  1: one-cycle pulse on frame completion.

Function
REQ-011 The FSM SHALL have states IDLE, FETCH, START, DATA and STOP.
REQ-012 IDLE: o_rden SHALL be combinationally (state==IDLE && !i_empty); on that edge the FSM SHALL go to FETCH, otherwise it stays in IDLE.
REQ-013 o_rden SHALL never be high while i_empty is high, and SHALL pulse exactly once per frame.
REQ-014 FETCH (exactly 1 cycle): i_rddata SHALL be latched into a WIDTH-bit shift register, the baud counter cleared, and the FSM SHALL go to START.
REQ-015 START: o_tx=0 for exactly CLKS_PER_BIT cycles, then DATA.
REQ-016 DATA: o_tx SHALL present shift-register bit 0, holding each bit for CLKS_PER_BIT cycles, shifting right after each bit; after WIDTH bits it SHALL go to STOP.
REQ-017 STOP: o_tx=1 for CLKS_PER_BIT cycles, then IDLE.
REQ-018 o_tx SHALL be a registered output, changing only on the clock edge that enters a new state or bit.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1 with width $clog2(CLKS_PER_BIT), wrap to 0 at each bit boundary, and never overflow.
REQ-020 The bit index SHALL count 0..WIDTH-1, reset to 0 on FETCH.
REQ-021 o_busy SHALL be high in FETCH, START, DATA and STOP, and low in IDLE.
REQ-022 o_done SHALL be registered and high for exactly the first IDLE cycle after STOP.
REQ-023 Back-to-back operation: with the FIFO non-empty, o_tx SHALL remain high for exactly CLKS_PER_BIT+2 cycles between frames (STOP, IDLE, FETCH).
REQ-024 Changes of i_empty outside IDLE SHALL be ignored; a frame in progress always completes.
REQ-025 i_rddata SHALL be ignored in every state except FETCH.
REQ-026 A frame SHALL be WIDTH+2 bit times (CLKS_PER_BIT*(WIDTH+2) cycles) from START entry to STOP exit.

Reset
REQ-027 While rst_n=0: state=IDLE, o_tx=1, o_busy=0, o_done=0, o_rden=0, counters and shift register cleared; all take effect asynchronously.
REQ-028 Reset mid-frame SHALL abort the frame: the line returns high immediately and the partially sent word is discarded, not re-read.
REQ-029 After rst_n deasserts, the first o_rden SHALL occur no earlier than the first rising edge with rst_n=1 and i_empty=0.

Verification (CLKS_PER_BIT=4, WIDTH=8)
REQ-030 Reset released, i_empty=1 for 100 cycles -> o_tx=1, o_rden=0, o_busy=0, o_done=0 throughout.
REQ-031 Single word 0xA5 -> one o_rden pulse; o_tx: 4 cycles 0, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then 4 cycles 1; o_done pulses once, 40 cycles after START entry.
REQ-032 FIFO holds 0x00, 0xFF, 0x55 -> exactly 3 o_rden pulses; decoded bytes in order; o_tx high for exactly 6 cycles between consecutive frames.
REQ-033 i_empty goes high during DATA of the last word -> frame completes intact; no further o_rden; o_busy falls with o_done.
REQ-034 rst_n pulled low during DATA bit 3 of 0x3C -> o_tx=1 and o_busy=0 before the next clk edge; after release with FIFO holding 0x81, the next frame carries 0x81 with a fresh o_rden.
REQ-035 Scoreboard across random words and random i_empty patterns -> every serial byte matches FIFO order; o_rden is never high with i_empty=1.
